// File: rtl/time_msg_pkg.sv
// Shared definitions for the time message transmitter.
// FRAME_LEN : number of bytes in one frame (2 header, 8 payload, 1 checksum)
// IDX_W     : width of the byte index inside a frame
// state_t   : transmitter FSM states
package time_msg_pkg;

    localparam int FRAME_LEN = 11;
    localparam int IDX_W     = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/time_msg_tx_if.sv
// Byte stream channel from the time message transmitter to its consumer.
// tx_data  : frame byte
// tx_valid : tx_data holds a valid byte
// tx_ready : consumer accepts the byte
// Handshake: a byte moves on a clock edge where tx_valid and tx_ready are
// both high; while tx_valid is high and tx_ready is low the source holds
// tx_data unchanged, and tx_valid never drops before the byte has moved.
interface time_msg_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/time_msg_tx.sv
// Time message transmitter. On a snap request in IDLE the current time
// fields and their checksum are captured, then sent as an 11-byte frame:
// HDR0, HDR1, year, month, day, hour, minute, second, ms[15:8], ms[7:0],
// checksum (8-bit sum of the eight payload bytes).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   snap              : one-cycle capture-and-send request
//   year..second      : 8-bit time fields
//   msecond           : 16-bit millisecond field
//   tx                : byte stream channel (master side)
//   busy              : a frame is in progress
//   drop_cnt          : saturating count of snap requests ignored while busy
//   dbg_state         : current FSM state
module time_msg_tx
    import time_msg_pkg::*;
#(
    parameter logic [7:0] HDR0 = 8'hA5,
    parameter logic [7:0] HDR1 = 8'h5A
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                snap,
    input  logic [7:0]          year,
    input  logic [7:0]          month,
    input  logic [7:0]          day,
    input  logic [7:0]          hour,
    input  logic [7:0]          minute,
    input  logic [7:0]          second,
    input  logic [15:0]         msecond,
    time_msg_tx_if.master       tx,
    output logic                busy,
    output logic [7:0]          drop_cnt,
    output state_t              dbg_state
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       drop_q, drop_d;
    // Captured frame bytes 2..10 (payload then checksum).
    logic [7:0]       cap_q [9];
    logic [7:0]       cap_d [9];

    logic [7:0]       csum;
    logic [IDX_W-1:0] nxt;
    logic [IDX_W-1:0] cap_sel;
    logic             fire;

    always_comb begin
        csum = year + month + day + hour + minute + second
             + msecond[15:8] + msecond[7:0];

        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        drop_d  = drop_q;
        cap_d   = cap_q;

        fire    = valid_q && tx.tx_ready;
        nxt     = idx_q + 4'd1;
        // Header byte 1 is not in the capture array; clamp to keep the
        // index in range when nxt selects it.
        cap_sel = (nxt >= 4'd2) ? (nxt - 4'd2) : '0;

        case (state_q)
            IDLE: begin
                if (snap) begin
                    cap_d   = '{year, month, day, hour, minute, second,
                                msecond[15:8], msecond[7:0], csum};
                    data_d  = HDR0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Requests during a frame, including its final edge, are lost.
                if (snap && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                if (fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = nxt;
                        data_d = (nxt == 4'd1) ? HDR1 : cap_q[cap_sel];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 8'h00;
            cap_q   <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            cap_q   <= cap_d;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = busy_q;
    assign drop_cnt    = drop_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/time_msg_tx.md
TIME_MSG_TX -- requirements
Module: time_msg_tx

Interface
REQ-001 The block SHALL have parameter HDR0, default 8'hA5, meaning first frame header byte.
REQ-002 The block SHALL have parameter HDR1, default 8'h5A, meaning second frame header byte.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is single clock domain.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port snap, input, 1, one-cycle request to capture and transmit the current time.
REQ-006 The block SHALL have ports year, month, day, hour, minute, second, each input, 8, time-of-day fields from the time counter.
REQ-007 The block SHALL have port msecond, input, 16, millisecond field (0..999).
REQ-008 The block SHALL have port tx_data, output, 8, frame byte.
REQ-009 The block SHALL have port tx_valid, output, 1, tx_data holds a valid byte.
REQ-010 The block SHALL have port tx_ready, input, 1, downstream accepts the byte when high with tx_valid.
REQ-011 The block SHALL have port busy, output, 1, a frame is in progress.
REQ-012 The block SHALL have port drop_cnt, output, 8, count of snap requests discarded while busy.

Function
REQ-013 Frame: 11 bytes, in order HDR0, HDR1, year, month, day, hour, minute, second, msecond[15:8], msecond[7:0], checksum.
REQ-014 Checksum: 8-bit sum modulo 256 of bytes 2..9; overflow discarded.
REQ-015 FSM states: IDLE (tx_valid=0, busy=0) and SEND (tx_valid=1, busy=1).
REQ-016 IDLE with snap=1: register all seven fields and the checksum in the same edge; enter SEND with byte index 0.
REQ-017 Latency: snap sampled at edge N gives tx_valid=1 with tx_data=HDR0 after edge N.
REQ-018 Handshake: a byte transfers on an edge where tx_valid=1 and tx_ready=1; the byte index then increments.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data and the byte index SHALL hold unchanged.
REQ-020 tx_ready SHALL be ignored in IDLE.
REQ-021 Transfer of byte 10: return to IDLE; tx_valid drops after that edge.
REQ-022 snap=1 in SEND, including the edge that transfers byte 10: discard the request and increment drop_cnt.
REQ-023 drop_cnt saturates at 8'hFF.
REQ-024 Input field changes after capture SHALL NOT alter the frame in flight.
REQ-025 tx_data SHALL be driven from registers only, with no combinational path from any input.

Reset
REQ-026 rst=1 asynchronously forces: FSM to IDLE, byte index 0, tx_valid=0, busy=0, tx_data=8'h00, drop_cnt=0, captured fields and checksum=0.
REQ-027 rst asserted mid-frame aborts the frame with no further bytes; the first frame after release starts from HDR0 only on a new snap.
REQ-028 Deassertion of rst SHALL be followed by at least one edge before snap is honoured; snap on the first edge after release is legal and is captured.

Structure
REQ-029 Shared package time_msg_pkg SHALL hold FRAME_LEN=11, the state enumeration and byte-index width (4 bits).
REQ-030 The block SHALL be a single module with no sub-modules; checksum adder is inline.

Verification
REQ-031 Fields 5,3,14,9,30,45, msecond=500, tx_ready=1 held, one snap -> bytes A5,5A,05,03,0E,09,1E,2D,01,F4,5F on 11 consecutive edges; busy low after.
REQ-032 Same frame with tx_ready toggling 1/0 every cycle -> identical byte sequence; tx_data stable during every stall; 21 cycles of tx_valid.
REQ-033 Fields all 8'hFF, msecond=16'hFFFF -> checksum 8'hF8 (sum 2040 mod 256).
REQ-034 Three snaps during one frame -> frame unaltered, drop_cnt=3; 300 snaps while tx_ready=0 -> drop_cnt=255.
REQ-035 rst asserted at byte index 5 -> tx_valid=0 and drop_cnt=0 immediately, no clock needed; after release and a new snap the frame begins with A5.
REQ-036 Field inputs changed every cycle during SEND -> transmitted bytes match the values present at the snap edge.
